// File: rtl/PKG_pwm.sv
// ---------------------------------------------------------------------------
// PKG_pwm -- shared definitions for the 1x8 PWM compare-value demux.
//
// Contents:
//   `PWMCOUNT_WIDTH  width of a PWM compare value (default 16)
//   PWMCOUNT_WIDTH   the same width as a package constant
//   NUM_CH           number of compare channels (8)
//   SEL_W            width of the channel select
//   state_e          commit FSM states (IDLE, ARMED)
//   sel_onehot()     channel select to one-hot write-enable decode
// ---------------------------------------------------------------------------
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package PKG_pwm;

    localparam int PWMCOUNT_WIDTH = `PWMCOUNT_WIDTH;
    localparam int NUM_CH         = 8;
    localparam int SEL_W          = $clog2(NUM_CH);

    // IDLE accepts writes and commits; ARMED waits for carrier-zero strobes
    // to transfer every pending shadow value into its active register.
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_16bits_1x8_if.sv
// ---------------------------------------------------------------------------
// demux_16bits_1x8_if -- write/commit bus of the PWM compare-value demux.
//
// Signals:
//   in_valid  write request             (master -> slave)
//   in_ready  write acceptance          (slave  -> master)
//   in_sel    target channel 0..7       (master -> slave)
//   in_data   compare value             (master -> slave)
//   commit    apply pending values      (master -> slave)
//   upd       per-channel carrier-zero  (master -> slave)
//
// Modports:
//   master  the agent that programs compare values
//   slave   the demux side
// ---------------------------------------------------------------------------
interface demux_16bits_1x8_if;
    import PKG_pwm::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          in_sel;
    logic [PWMCOUNT_WIDTH-1:0] in_data;
    logic                      commit;
    logic [NUM_CH-1:0]         upd;

    modport master (
        output in_valid,
        output in_sel,
        output in_data,
        output commit,
        output upd,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_sel,
        input  in_data,
        input  commit,
        input  upd,
        output in_ready
    );

endinterface

// File: rtl/pwm_cmp_slot.sv
// ---------------------------------------------------------------------------
// pwm_cmp_slot -- storage for one PWM compare channel.
//
// With PWMDEMUX_SHADOW_EN defined the slot holds a shadow value, a pending
// flag and the active compare value; a write lands in the shadow and sets
// pending, an apply strobe moves a pending shadow value into the active
// register. Without the macro the slot is only the active register, written
// directly.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   wr_en       write this channel
//   wr_data     value to write
//   apply       carrier-zero strobe, already qualified by the ARMED state
//   active      registered active compare value
//   pend        shadow holds a value not yet applied
// ---------------------------------------------------------------------------
module pwm_cmp_slot
    import PKG_pwm::*;
#(
    parameter logic [PWMCOUNT_WIDTH-1:0] RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [PWMCOUNT_WIDTH-1:0] wr_data,
    input  logic                      apply,
    output logic [PWMCOUNT_WIDTH-1:0] active,
    output logic                      pend
);

`ifdef PWMDEMUX_SHADOW_EN

    logic [PWMCOUNT_WIDTH-1:0] shadow_q, shadow_d;
    logic [PWMCOUNT_WIDTH-1:0] active_q, active_d;
    logic                      pend_q,   pend_d;

    always_comb begin
        // NOTE: every output of this block is given its held value first so
        // that no path leaves one unassigned, which would infer a latch.
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        // A write and an apply never coincide: writes are only accepted in
        // IDLE and apply only fires in ARMED. The write still takes priority
        // so a newly written value can never be lost.
        if (wr_en) begin
            shadow_d = wr_data;
            pend_d   = 1'b1;
        end else if (apply && pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow is reset along with the active value; a reset
            // must discard pending values so none can surface afterwards.
            shadow_q <= RST_VAL;
            active_q <= RST_VAL;
            pend_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
        end
    end

    assign active = active_q;
    assign pend   = pend_q;

`else

    logic [PWMCOUNT_WIDTH-1:0] active_q, active_d;
    logic                      unused_apply;

    // Carrier-zero strobes have no meaning without a shadow stage.
    assign unused_apply = apply;

    always_comb begin
        active_d = active_q;
        if (wr_en) begin
            active_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= RST_VAL;
        end else begin
            active_q <= active_d;
        end
    end

    assign active = active_q;
    assign pend   = 1'b0;

`endif

endmodule

// File: rtl/demux_16bits_1x8.sv
// ---------------------------------------------------------------------------
// demux_16bits_1x8 -- 1-to-8 demux of PWM compare values with optional
// shadow/commit double buffering.
//
// Configuration macro: PWMDEMUX_SHADOW_EN
//   defined   : writes go to per-channel shadow registers; commit arms the
//               block; each channel's upd strobe (carrier zero) then moves
//               its pending value to out_n. done pulses once all pending
//               channels have been applied (or at once if nothing pending).
//   undefined : writes update out_n directly, pend is 0, in_ready is 1,
//               commit pulses done the next cycle, upd is ignored.
//
// Parameter:
//   RST_VAL        reset value of every shadow and active register
//
// Ports:
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid/ready write handshake; transfer when both are 1 at an edge
//   in_sel         target channel 0..7
//   in_data        value for the target channel
//   commit         single-cycle request to apply pending values
//   upd            per-channel carrier-zero strobes
//   out_0..out_7   registered active compare values
//   pend           per-channel "shadow not yet applied" flags
//   done           one-cycle pulse when a commit completes
// ---------------------------------------------------------------------------
module demux_16bits_1x8
    import PKG_pwm::*;
#(
    parameter logic [`PWMCOUNT_WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_sel,
    input  logic [`PWMCOUNT_WIDTH-1:0] in_data,
    input  logic                       commit,
    input  logic [7:0]                 upd,
    output logic [`PWMCOUNT_WIDTH-1:0] out_0,
    output logic [`PWMCOUNT_WIDTH-1:0] out_1,
    output logic [`PWMCOUNT_WIDTH-1:0] out_2,
    output logic [`PWMCOUNT_WIDTH-1:0] out_3,
    output logic [`PWMCOUNT_WIDTH-1:0] out_4,
    output logic [`PWMCOUNT_WIDTH-1:0] out_5,
    output logic [`PWMCOUNT_WIDTH-1:0] out_6,
    output logic [`PWMCOUNT_WIDTH-1:0] out_7,
    output logic [7:0]                 pend,
    output logic                       done
);

    logic                      wr_fire;
    logic [NUM_CH-1:0]         wr_en;
    logic [NUM_CH-1:0]         apply;
    logic [NUM_CH-1:0]         pend_vec;
    logic [PWMCOUNT_WIDTH-1:0] active [NUM_CH];
    logic                      done_q, done_d;

    assign wr_fire = in_valid && in_ready;
    assign wr_en   = wr_fire ? sel_onehot(in_sel) : '0;

`ifdef PWMDEMUX_SHADOW_EN

    state_e state_q, state_d;

    // Writes are held off while a commit is in flight so the shadow values
    // being applied cannot change under the carrier-zero strobes.
    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        apply   = '0;
        case (state_q)
            IDLE: begin
                // A write accepted on the commit edge belongs to this commit,
                // so the pending test includes it.
                if (commit) begin
                    if ((pend_vec | wr_en) != '0) begin
                        state_d = ARMED;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                // Slots ignore apply unless pending; commit is ignored here.
                apply = upd;
                if ((pend_vec & ~upd) == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`else

    logic unused_upd;

    assign unused_upd = ^upd;
    assign in_ready   = 1'b1;
    assign apply      = '0;

    always_comb begin
        done_d = commit;
    end

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
        pwm_cmp_slot #(
            .RST_VAL (RST_VAL)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[n]),
            .wr_data (in_data),
            .apply   (apply[n]),
            .active  (active[n]),
            .pend    (pend_vec[n])
        );
    end

    assign out_0 = active[0];
    assign out_1 = active[1];
    assign out_2 = active[2];
    assign out_3 = active[3];
    assign out_4 = active[4];
    assign out_5 = active[5];
    assign out_6 = active[6];
    assign out_7 = active[7];
    assign pend  = pend_vec;
    assign done  = done_q;

endmodule

// File: tb/tb_demux_16bits_1x8.sv
// ---------------------------------------------------------------------------
// tb_demux_16bits_1x8 -- self-checking bench for demux_16bits_1x8.
// Follows PWMDEMUX_SHADOW_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_demux_16bits_1x8;
    import PKG_pwm::*;

`ifdef PWMDEMUX_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif
    localparam logic [15:0] RST_VAL = 16'h0000;

    logic clk;
    logic rst_n;
    demux_16bits_1x8_if bus ();

    logic [15:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
    logic [7:0]  pend;
    logic        done;
    logic [15:0] dut_out [8];

    demux_16bits_1x8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .in_sel   (bus.in_sel),
        .in_data  (bus.in_data),
        .commit   (bus.commit),
        .upd      (bus.upd),
        .out_0    (out_0),
        .out_1    (out_1),
        .out_2    (out_2),
        .out_3    (out_3),
        .out_4    (out_4),
        .out_5    (out_5),
        .out_6    (out_6),
        .out_7    (out_7),
        .pend     (pend),
        .done     (done)
    );

    assign dut_out[0] = out_0;
    assign dut_out[1] = out_1;
    assign dut_out[2] = out_2;
    assign dut_out[3] = out_3;
    assign dut_out[4] = out_4;
    assign dut_out[5] = out_5;
    assign dut_out[6] = out_6;
    assign dut_out[7] = out_7;

    int n_checks = 0;
    int n_fail   = 0;
    bit compare_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: channel arrays updated from the rules of each mode.
    logic [15:0] exp_out    [8];
    logic [15:0] exp_shadow [8];
    logic [7:0]  exp_pend;
    bit          exp_armed;
    bit          exp_done;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int n = 0; n < 8; n++) begin
                    exp_out[n]    = RST_VAL;
                    exp_shadow[n] = RST_VAL;
                end
                exp_pend  = 8'h00;
                exp_armed = 1'b0;
                exp_done  = 1'b0;
            end else begin
`ifdef PWMDEMUX_SHADOW_EN
                exp_done = 1'b0;
                if (exp_armed) begin
                    for (int n = 0; n < 8; n++) begin
                        if (bus.upd[n] && exp_pend[n]) begin
                            exp_out[n]  = exp_shadow[n];
                            exp_pend[n] = 1'b0;
                        end
                    end
                    if (exp_pend == 8'h00) begin
                        exp_armed = 1'b0;
                        exp_done  = 1'b1;
                    end
                end else begin
                    if (bus.in_valid) begin
                        exp_shadow[bus.in_sel] = bus.in_data;
                        exp_pend[bus.in_sel]   = 1'b1;
                    end
                    if (bus.commit) begin
                        if (exp_pend != 8'h00) exp_armed = 1'b1;
                        else                   exp_done  = 1'b1;
                    end
                end
`else
                exp_done = bus.commit;
                if (bus.in_valid) exp_out[bus.in_sel] = bus.in_data;
`endif
            end
        end
    end

    // Cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (compare_en) begin
                for (int n = 0; n < 8; n++) begin
                    check($sformatf("cyc out_%0d", n), {16'h0, dut_out[n]}, {16'h0, exp_out[n]});
                end
                check("cyc pend", {24'h0, pend}, {24'h0, exp_pend});
                check("cyc done", {31'h0, done}, {31'h0, exp_done});
                check("cyc in_ready", {31'h0, bus.in_ready}, {31'h0, (SH ? !exp_armed : 1'b1)});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.commit   = 1'b0;
        bus.upd      = 8'h00;
    endtask

    task automatic do_write_c(input logic [2:0] sel, input logic [15:0] data, input logic with_commit);
        logic rdy;
        int   waited;
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
        bus.commit   = with_commit;
        rdy    = 1'b0;
        waited = 0;
        while (!rdy && waited < 50) begin
            rdy = bus.in_ready;
            tick();
            waited++;
        end
        check("write accepted within budget", {31'h0, rdy}, 32'h1);
        idle_inputs();
    endtask

    task automatic do_write(input logic [2:0] sel, input logic [15:0] data);
        do_write_c(sel, data, 1'b0);
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
    endtask

    task automatic do_upd(input logic [7:0] mask);
        bus.upd = mask;
        tick();
        bus.upd = 8'h00;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.in_sel  = 3'd0;
        bus.in_data = 16'h0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        compare_en = 1'b1;
        check("reset in_ready", {31'h0, bus.in_ready}, 32'h1);
        check("reset pend", {24'h0, pend}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset out_3", {16'h0, out_3}, 32'h0);
        tick();

        // Single write, commit, carrier-zero on channel 3.
        do_write(3'd3, 16'h1234);
        check("w3 pend", {24'h0, pend}, SH ? 32'h08 : 32'h0);
        check("w3 out_3 before upd", {16'h0, out_3}, SH ? 32'h0 : 32'h1234);
        do_commit();
        check("w3 commit in_ready", {31'h0, bus.in_ready}, SH ? 32'h0 : 32'h1);
        check("w3 commit done", {31'h0, done}, SH ? 32'h0 : 32'h1);
        do_upd(8'h08);
        check("w3 out_3 after upd", {16'h0, out_3}, 32'h1234);
        check("w3 done after upd", {31'h0, done}, SH ? 32'h1 : 32'h0);
        check("w3 out_4 untouched", {16'h0, out_4}, 32'h0);
        tick();
        check("w3 done one cycle", {31'h0, done}, 32'h0);

        // Two writes to one channel: only the last survives.
        do_write(3'd5, 16'h0010);
        do_write(3'd5, 16'h0020);
        do_commit();
        do_upd(8'h20);
        check("w5 out_5 last value", {16'h0, out_5}, 32'h0020);
        check("w5 out_3 kept", {16'h0, out_3}, 32'h1234);
        tick();

        // Three channels applied on one strobe edge.
        do_write(3'd0, 16'h000A);
        do_write(3'd1, 16'h000B);
        do_write(3'd7, 16'h000C);
        do_commit();
        check("multi out_0 before upd", {16'h0, out_0}, SH ? 32'h0 : 32'hA);
        do_upd(8'h83);
        check("multi out_0", {16'h0, out_0}, 32'hA);
        check("multi out_1", {16'h0, out_1}, 32'hB);
        check("multi out_7", {16'h0, out_7}, 32'hC);
        check("multi done", {31'h0, done}, SH ? 32'h1 : 32'h0);
        tick();
        check("multi single done", {31'h0, done}, 32'h0);

        // Commit with nothing pending.
        do_commit();
        check("empty commit done", {31'h0, done}, 32'h1);
        check("empty commit in_ready", {31'h0, bus.in_ready}, 32'h1);
        tick();
        check("empty commit done clears", {31'h0, done}, 32'h0);

        // Write stalls in ARMED; stray upd and commit in ARMED are ignored.
        do_write(3'd1, 16'h0111);
        do_write(3'd2, 16'h0222);
        do_commit();
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd2;
        bus.in_data  = 16'hFFFF;
        bus.upd      = 8'h01;
        bus.commit   = 1'b1;
        tick();
        bus.commit = 1'b0;
        check("stall in_ready", {31'h0, bus.in_ready}, SH ? 32'h0 : 32'h1);
        check("stall pend", {24'h0, pend}, SH ? 32'h06 : 32'h0);
        check("stall out_0", {16'h0, out_0}, 32'hA);
        check("stall out_2", {16'h0, out_2}, SH ? 32'h0 : 32'hFFFF);
        check("armed commit ignored", {31'h0, done}, SH ? 32'h0 : 32'h1);
        bus.upd = 8'h02;
        tick();
        bus.upd = 8'h04;
        tick();
        bus.upd = 8'h00;
        check("stall out_1", {16'h0, out_1}, 32'h0111);
        check("stall out_2 applied", {16'h0, out_2}, SH ? 32'h0222 : 32'hFFFF);
        check("stall done", {31'h0, done}, SH ? 32'h1 : 32'h0);
        check("stall back idle", {31'h0, bus.in_ready}, 32'h1);
        tick();
        idle_inputs();
        check("stalled write landed", {24'h0, pend}, SH ? 32'h04 : 32'h0);
        do_commit();
        do_upd(8'h04);
        check("stalled write applied", {16'h0, out_2}, 32'hFFFF);
        tick();

        // Write on the commit edge belongs to that commit.
        do_write_c(3'd6, 16'h0066, 1'b1);
        check("wc pend", {24'h0, pend}, SH ? 32'h40 : 32'h0);
        check("wc in_ready", {31'h0, bus.in_ready}, SH ? 32'h0 : 32'h1);
        check("wc done", {31'h0, done}, SH ? 32'h0 : 32'h1);
        do_upd(8'h40);
        check("wc out_6", {16'h0, out_6}, 32'h0066);
        check("wc done after upd", {31'h0, done}, SH ? 32'h1 : 32'h0);
        tick();

        // Reset in the middle of ARMED discards everything.
        for (int n = 0; n < 4; n++) begin
            do_write(3'(n), 16'h1000 + 16'(n));
        end
        do_commit();
        check("pre-reset pend", {24'h0, pend}, SH ? 32'h0F : 32'h0);
        rst_n = 1'b0;
        #1;
        for (int n = 0; n < 8; n++) begin
            check($sformatf("async reset out_%0d", n), {16'h0, dut_out[n]}, {16'h0, RST_VAL});
        end
        check("async reset pend", {24'h0, pend}, 32'h0);
        check("async reset done", {31'h0, done}, 32'h0);
        check("async reset in_ready", {31'h0, bus.in_ready}, 32'h1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_upd(8'hFF);
        for (int n = 0; n < 8; n++) begin
            check($sformatf("post-reset upd out_%0d", n), {16'h0, dut_out[n]}, {16'h0, RST_VAL});
        end
        check("post-reset pend", {24'h0, pend}, 32'h0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
